// File: rtl/gate3_sweep_driver.sv
// gate3_sweep_driver: drives a 3-input gate through all eight input vectors,
// captures its synchronized output per vector and grades the truth table.
`timescale 1ns/1ps
module gate3_sweep_driver #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'b0000_0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth,
  output logic [3:0] err_count,
  output logic [2:0] first_err_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       state, state_next;
  logic [2:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err_seen, err_seen_next;
  logic             sync1, sync2;
  logic             busy_next, done_next, pass_next;
  logic [7:0]       truth_next;
  logic [3:0]       err_count_next;
  logic [2:0]       first_err_idx_next;
  logic             mismatch;

  // Vector index is held in a flop, so the gate inputs come straight from it.
  assign a = idx[2];
  assign b = idx[1];
  assign c = idx[0];

  // Two-flop synchronizer for the possibly asynchronous gate output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= gate_out;
      sync2 <= sync1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      err_seen      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      truth         <= 8'd0;
      err_count     <= 4'd0;
      first_err_idx <= 3'd0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      cnt           <= cnt_next;
      err_seen      <= err_seen_next;
      busy          <= busy_next;
      done          <= done_next;
      pass          <= pass_next;
      truth         <= truth_next;
      err_count     <= err_count_next;
      first_err_idx <= first_err_idx_next;
    end
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_next         = state;
    idx_next           = idx;
    cnt_next           = cnt;
    err_seen_next      = err_seen;
    busy_next          = busy;
    done_next          = 1'b0;
    pass_next          = pass;
    truth_next         = truth;
    err_count_next     = err_count;
    first_err_idx_next = first_err_idx;
    mismatch           = (sync2 != EXPECTED[idx]);

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next         = ST_SETTLE;
          idx_next           = 3'd0;
          cnt_next           = '0;
          truth_next         = 8'd0;
          err_count_next     = 4'd0;
          first_err_idx_next = 3'd0;
          pass_next          = 1'b0;
          err_seen_next      = 1'b0;
          busy_next          = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        truth_next[idx] = sync2;
        if (mismatch) begin
          err_count_next = err_count + 4'd1;
          if (!err_seen) begin
            first_err_idx_next = idx;
            err_seen_next      = 1'b1;
          end
        end
        if (idx == 3'd7) begin
          state_next = ST_FINISH;
        end else begin
          idx_next   = idx + 3'd1;
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        // truth already holds the vector-7 capture from the SAMPLE edge.
        done_next  = 1'b1;
        pass_next  = (truth == EXPECTED);
        busy_next  = 1'b0;
        idx_next   = 3'd0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate3_sweep_driver.sv
// Bench for gate3_sweep_driver: behavioural gate models feed two instances
// (default NOR3 expectation and a NAND3 expectation); results are graded
// through a scoreboard queue filled when each sweep is launched.
`timescale 1ns/1ps
module tb_gate3_sweep_driver;

  typedef struct packed {
    logic [7:0] truth;
    logic [3:0] err;
    logic [2:0] first;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2, gate1, gate2;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic       a2, b2, c2, busy2, done2, pass2;
  logic [7:0] truth1, truth2;
  logic [3:0] err1, err2;
  logic [2:0] first1, first2;

  int mode = 0;   // 0 NOR3, 1 stuck-0, 2 stuck-1, 3 NAND3
  int sel  = 0;   // which instance the checks look at
  int tests = 0;
  int fails = 0;
  res_t sb[$];

  function automatic logic gate_fn(input int m, input logic [2:0] v);
    case (m)
      0:       gate_fn = ~|v;
      1:       gate_fn = 1'b0;
      2:       gate_fn = 1'b1;
      default: gate_fn = ~&v;
    endcase
  endfunction

  assign gate1 = gate_fn(mode, {a1, b1, c1});
  assign gate2 = gate_fn(mode, {a2, b2, c2});

  gate3_sweep_driver dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_out(gate1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .truth(truth1), .err_count(err1), .first_err_idx(first1)
  );

  gate3_sweep_driver #(.SETTLE(4), .EXPECTED(8'h7F)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_out(gate2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .truth(truth2), .err_count(err2), .first_err_idx(first2)
  );

  logic [2:0] vec_s;
  logic       busy_s, done_s, pass_s;
  logic [7:0] truth_s;
  logic [3:0] err_s;
  logic [2:0] first_s;
  assign vec_s   = (sel != 0) ? {a2, b2, c2} : {a1, b1, c1};
  assign busy_s  = (sel != 0) ? busy2  : busy1;
  assign done_s  = (sel != 0) ? done2  : done1;
  assign pass_s  = (sel != 0) ? pass2  : pass1;
  assign truth_s = (sel != 0) ? truth2 : truth1;
  assign err_s   = (sel != 0) ? err2   : err1;
  assign first_s = (sel != 0) ? first2 : first1;

  // Reference grading of an ideal sweep against an expected pattern.
  function automatic res_t model(input int m, input logic [7:0] exp_tab);
    res_t r;
    logic [7:0] diff;
    int n;
    bit found;
    r = '0;
    for (int v = 0; v < 8; v++) r.truth[v] = gate_fn(m, 3'(v));
    diff = r.truth ^ exp_tab;
    n = 0;
    found = 0;
    for (int v = 0; v < 8; v++) begin
      if (diff[v]) begin
        n++;
        if (!found) begin
          r.first = 3'(v);
          found = 1;
        end
      end
    end
    r.err  = 4'(n);
    r.pass = (diff == 8'd0);
    return r;
  endfunction

  // Launch one sweep, optionally check the vector sequence, then grade it.
  task automatic run_sweep(input string name, input int s, input int m,
                           input logic [7:0] exp_tab, input bit chk_seq);
    res_t e;
    int cyc;
    bit seen;
    sel  = s;
    mode = m;
    sb.push_back(model(m, exp_tab));
    @(negedge clk);
    if (s != 0) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    cyc  = 0;
    seen = 0;
    tests++;
    if (busy_s !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy_s);
    end
    while (!seen && cyc < 200) begin
      if (chk_seq && cyc < 40) begin
        tests++;
        if (vec_s !== 3'(cyc / 5)) begin
          fails++;
          $display("FAIL %s vector@%0d: got %0d want %0d", name, cyc, vec_s, cyc / 5);
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done_s === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
      void'(sb.pop_front());
    end else begin
      if (cyc != 41) begin
        fails++;
        $display("FAIL %s done_cycle: got %0d want 41", name, cyc);
      end
      e = sb.pop_front();
      tests++;
      if (truth_s !== e.truth) begin
        fails++;
        $display("FAIL %s truth: got %h want %h", name, truth_s, e.truth);
      end
      tests++;
      if (err_s !== e.err) begin
        fails++;
        $display("FAIL %s err_count: got %0d want %0d", name, err_s, e.err);
      end
      tests++;
      if (first_s !== e.first) begin
        fails++;
        $display("FAIL %s first_err_idx: got %0d want %0d", name, first_s, e.first);
      end
      tests++;
      if (pass_s !== e.pass || busy_s !== 1'b0) begin
        fails++;
        $display("FAIL %s pass/busy: got %b/%b want %b/0", name, pass_s, busy_s, e.pass);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (done_s !== 1'b0 || pass_s !== e.pass || truth_s !== e.truth) begin
        fails++;
        $display("FAIL %s hold_after_done: done=%b pass=%b truth=%h want 0/%b/%h",
                 name, done_s, pass_s, truth_s, e.pass, e.truth);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({a1, b1, c1, busy1, done1, pass1, truth1, err1, first1} !== 21'd0) begin
      fails++;
      $display("FAIL reset_dut1: got %h want 0",
               {a1, b1, c1, busy1, done1, pass1, truth1, err1, first1});
    end
    tests++;
    if ({a2, b2, c2, busy2, done2, pass2, truth2, err2, first2} !== 21'd0) begin
      fails++;
      $display("FAIL reset_dut2: got %h want 0",
               {a2, b2, c2, busy2, done2, pass2, truth2, err2, first2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t e;
    int d[2];
    int nd;
    int wait_cyc;
    sel  = 0;
    mode = 0;
    nd   = 0;
    d[0] = -1;
    d[1] = -1;
    sb.push_back(model(0, 8'h01));
    sb.push_back(model(0, 8'h01));
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1 === 1'b1) begin
        if (nd < 2) begin
          d[nd] = cyc;
          e = sb.pop_front();
          tests++;
          if (truth1 !== e.truth || pass1 !== e.pass) begin
            fails++;
            $display("FAIL b2b_result%0d: truth=%h pass=%b want %h/%b",
                     nd, truth1, pass1, e.truth, e.pass);
          end
        end
        nd++;
      end
      if (cyc == 42) begin
        tests++;
        if (truth1 !== 8'd0 || pass1 !== 1'b0 || busy1 !== 1'b1) begin
          fails++;
          $display("FAIL b2b_clear: truth=%h pass=%b busy=%b want 00/0/1",
                   truth1, pass1, busy1);
        end
      end
    end
    start1 = 1'b0;
    tests++;
    if (nd != 2 || d[0] != 41 || d[1] != 83) begin
      fails++;
      $display("FAIL b2b_done_cycles: got n=%0d at %0d,%0d want 2 at 41,83", nd, d[0], d[1]);
    end
    while (sb.size() != 0) void'(sb.pop_front());
    wait_cyc = 0;
    while (busy1 !== 1'b0 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: busy still %b after %0d cycles", busy1, wait_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    int ndone;
    sel  = 0;
    mode = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (27) begin
      @(posedge clk);
      @(negedge clk);
    end
    tests++;
    if ({a1, b1, c1} !== 3'd5 || truth1 !== 8'h01) begin
      fails++;
      $display("FAIL midreset_pre: vec=%0d truth=%h want 5/01", {a1, b1, c1}, truth1);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a1, b1, c1, busy1, done1} !== 5'd0 || truth1 !== 8'd0) begin
      fails++;
      $display("FAIL midreset_clear: abc=%b busy=%b done=%b truth=%h want 0",
               {a1, b1, c1}, busy1, done1, truth1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL midreset_no_done: activity in %0d cycles want 0", ndone);
    end
    run_sweep("after_reset", 0, 0, 8'h01, 1'b0);
  endtask

  initial begin
    test_reset();
    run_sweep("nor_ideal", 0, 0, 8'h01, 1'b1);
    run_sweep("stuck0", 0, 1, 8'h01, 1'b0);
    run_sweep("stuck1", 0, 2, 8'h01, 1'b0);
    run_sweep("nand_exp7f", 1, 3, 8'h7F, 1'b1);
    run_sweep("nor_exp7f", 1, 0, 8'h7F, 1'b0);
    test_back_to_back();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
